// File: rtl/status_flag_unit.sv
// status_flag_unit: NZCV status register producer.
// Computes flags from the EX-stage ALU result, holds the architectural
// status register, and tracks in-flight flag-setting instructions so that
// conditional instructions in ID can stall until their flags are committed.
module status_flag_unit #(
    parameter int MAX_PENDING = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_s,
    input  logic [3:0]  ex_alu_cmd,
    input  logic [31:0] ex_op_a,
    input  logic [31:0] ex_op_b,
    input  logic [31:0] ex_result,
    input  logic        ex_cout,
    input  logic        stall,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [3:0]  wr_data,
    input  logic        id_issue_s,
    input  logic        id_needs_flags,
    output logic [3:0]  status,
    output logic        flag_hazard,
    output logic        issue_full
);

    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);

    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;

    logic [3:0]    status_reg, status_next;
    logic [CW-1:0] count_reg, count_next;

    logic          update;
    logic          is_add, is_sub;
    logic          flag_n, flag_z, flag_c, flag_v;
    logic          inc, dec;

    assign update = ex_valid & ex_s & ~stall & ~flush;
    assign is_add = (ex_alu_cmd == CMD_ADD) | (ex_alu_cmd == CMD_ADC);
    assign is_sub = (ex_alu_cmd == CMD_SUB) | (ex_alu_cmd == CMD_SBC);

    // Flag computation; logical/move commands keep C and V from the register
    always_comb begin
        flag_n = ex_result[31];
        flag_z = (ex_result == 32'd0);
        flag_c = status_reg[1];
        flag_v = status_reg[0];
        if (is_add) begin
            flag_c = ex_cout;
            flag_v = (ex_op_a[31] == ex_op_b[31]) & (ex_result[31] != ex_op_a[31]);
        end else if (is_sub) begin
            flag_c = ex_cout;
            flag_v = (ex_op_a[31] != ex_op_b[31]) & (ex_result[31] != ex_op_a[31]);
        end
    end

    // Status next-state: direct write beats an EX update; stall freezes both
    always_comb begin
        status_next = status_reg;
        if (wr_en && !stall) begin
            status_next = wr_data;
        end else if (update) begin
            status_next = {flag_n, flag_z, flag_c, flag_v};
        end
    end

    assign inc = id_issue_s & ~issue_full;
    assign dec = update & (count_reg != '0);

    // Scoreboard next-state: flush squashes everything in flight, stall holds
    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (!stall) begin
            if (inc && !dec) begin
                count_next = count_reg + 1'b1;
            end else if (dec && !inc) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            status_reg <= 4'b0000;
            count_reg  <= '0;
        end else begin
            status_reg <= status_next;
            count_reg  <= count_next;
        end
    end

    assign status      = status_reg;
    assign issue_full  = (count_reg == MAX_CNT);
    assign flag_hazard = id_needs_flags & (count_reg != '0);

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed testbench for status_flag_unit with hand-computed expectations.
module tb_status_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_s;
    logic [3:0]  ex_alu_cmd;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_result;
    logic        ex_cout;
    logic        stall;
    logic        flush;
    logic        wr_en;
    logic [3:0]  wr_data;
    logic        id_issue_s;
    logic        id_needs_flags;
    logic [3:0]  status;
    logic        flag_hazard;
    logic        issue_full;

    int checks_total  = 0;
    int checks_passed = 0;

    status_flag_unit #(.MAX_PENDING(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_s           (ex_s),
        .ex_alu_cmd     (ex_alu_cmd),
        .ex_op_a        (ex_op_a),
        .ex_op_b        (ex_op_b),
        .ex_result      (ex_result),
        .ex_cout        (ex_cout),
        .stall          (stall),
        .flush          (flush),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .id_issue_s     (id_issue_s),
        .id_needs_flags (id_needs_flags),
        .status         (status),
        .flag_hazard    (flag_hazard),
        .issue_full     (issue_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("ok   %-14s got=%0h", tag, got);
        end else begin
            $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic cout);
        ex_valid   = 1'b1;
        ex_s       = 1'b1;
        ex_alu_cmd = cmd;
        ex_op_a    = a;
        ex_op_b    = b;
        ex_result  = res;
        ex_cout    = cout;
    endtask

    initial begin
        rst = 1'b1; ex_valid = 0; ex_s = 0; ex_alu_cmd = 0; ex_op_a = 0; ex_op_b = 0;
        ex_result = 0; ex_cout = 0; stall = 0; flush = 0; wr_en = 0; wr_data = 0;
        id_issue_s = 0; id_needs_flags = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_status", status, 4'b0000);
        check("rst_hazard", flag_hazard, 0);
        check("rst_full", issue_full, 0);

        // ADD overflow into sign bit; no bypass before the edge
        ex_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        #1;
        check("add_nobypass", status, 4'b0000);
        step();
        check("add_ovf", status, 4'b1001);

        // CMP equal: Z and C set
        ex_op(4'b0100, 32'd5, 32'd5, 32'd0, 1'b1);
        step();
        check("cmp_eq", status, 4'b0110);

        // AND: N/Z from result, C and V kept
        ex_op(4'b0110, 32'hFFFF_FFFF, 32'hF000_0000, 32'hF000_0000, 1'b0);
        step();
        check("and_keep_cv", status, 4'b1010);

        // ADD zero without S bit: no change
        ex_op(4'b0010, 32'd0, 32'd0, 32'd0, 1'b0);
        ex_s = 1'b0;
        step();
        check("no_s", status, 4'b1010);
        // Same with S bit but stalled
        ex_s = 1'b1;
        stall = 1'b1;
        step();
        step();
        check("stall_hold", status, 4'b1010);
        stall = 1'b0;
        #1;
        check("stall_rel0", status, 4'b1010);
        step();
        check("stall_rel1", status, 4'b0100);
        ex_valid = 1'b0;
        ex_s = 1'b0;

        // Fill the scoreboard
        id_issue_s = 1'b1;
        step();
        check("iss1_hazard", flag_hazard, 1);
        check("iss1_full", issue_full, 0);
        step();
        check("iss2_full", issue_full, 0);
        step();
        check("iss3_full", issue_full, 1);
        step();
        check("iss4_full", issue_full, 1);
        id_issue_s = 1'b0;

        // Drain: 3->2, hold at 2 (issue+update), 2->1, 1->0
        ex_op(4'b0010, 32'd1, 32'd2, 32'd3, 1'b0);
        step();
        check("dec1_full", issue_full, 0);
        check("dec1_status", status, 4'b0000);
        id_issue_s = 1'b1;
        step();
        id_issue_s = 1'b0;
        check("coinc_full", issue_full, 0);
        check("coinc_hazard", flag_hazard, 1);
        step();
        check("dec3_hazard", flag_hazard, 1);
        step();
        check("dec4_hazard", flag_hazard, 0);
        id_needs_flags = 1'b0;
        check("nohz_uncond", flag_hazard, 0);
        id_needs_flags = 1'b1;
        // Update at count 0 must not underflow
        step();
        check("dec0_full", issue_full, 0);
        check("dec0_hazard", flag_hazard, 0);

        // Direct write wins over coincident update
        ex_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        wr_en = 1'b1;
        wr_data = 4'b0101;
        step();
        wr_en = 1'b0;
        check("wr_wins", status, 4'b0101);

        // Flush with count=2: count cleared, EX ignored
        ex_valid = 1'b0;
        id_issue_s = 1'b1;
        step();
        step();
        id_issue_s = 1'b0;
        check("pre_flush_hz", flag_hazard, 1);
        ex_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        flush = 1'b1;
        step();
        check("flush_status", status, 4'b0101);
        check("flush_hazard", flag_hazard, 0);
        // Flush still honours wr_en
        wr_en = 1'b1;
        wr_data = 4'b1111;
        step();
        check("flush_wr", status, 4'b1111);
        flush = 1'b0;
        ex_valid = 1'b0;
        // Stall blocks wr_en and issue
        stall = 1'b1;
        wr_data = 4'b0000;
        id_issue_s = 1'b1;
        step();
        check("stall_wr", status, 4'b1111);
        check("stall_issue", flag_hazard, 0);
        stall = 1'b0;
        wr_en = 1'b0;
        step();
        id_issue_s = 1'b0;
        check("post_stall_iss", flag_hazard, 1);

        // Reset mid-operation
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_status", status, 4'b0000);
        check("rst2_hazard", flag_hazard, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Producer side of the NZCV status register. Computes N, Z, C and V from the EX-stage ALU result for instructions with the S bit set, holds them in the architectural status register, and drives the 4-bit status vector consumed by the condition-check logic.
- Tracks in-flight flag-setting instructions with a scoreboard counter. A conditional instruction in ID can stall until the flags it depends on have been committed.

Parameters:
- MAX_PENDING, 3, maximum number of S-instructions tracked between ID issue and EX commit; counter width is clog2(MAX_PENDING+1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ex_valid  input  1  EX stage holds a live instruction
- ex_s  input  1  EX instruction has the S bit set
- ex_alu_cmd  input  4  ALU command: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB/CMP, 0101 SBC, 0110 AND/TST, 0111 ORR, 1000 EOR; other codes are treated as logical
- ex_op_a  input  32  ALU operand A
- ex_op_b  input  32  ALU operand B (post-shift)
- ex_result  input  32  ALU result
- ex_cout  input  1  raw carry-out of the ALU adder (for SUB/SBC this is the carry of a + ~b + cin)
- stall  input  1  pipeline stall; freezes status register and counter
- flush  input  1  squashes ID and EX contents
- wr_en  input  1  direct status write (MSR-style)
- wr_data  input  4  direct write value
- id_issue_s  input  1  an S-instruction leaves ID this cycle
- id_needs_flags  input  1  ID instruction is conditional (cond != 1110)
- status  output  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V
- flag_hazard  output  1  ID must stall for flags
- issue_full  output  1  counter is at MAX_PENDING

Behaviour:
- Reset (rst=1 at a rising edge): status=4'b0000, count=0. rst overrides every other input.
- update = ex_valid & ex_s & ~stall & ~flush.
- Flag values, computed combinationally and registered on update:
  - N = ex_result[31].
  - Z = (ex_result == 0).
  - Arithmetic commands (ADD, ADC, SUB, SBC): C = ex_cout.
  - V for ADD/ADC: (a[31]==b[31]) & (res[31]!=a[31]).
  - V for SUB/SBC: (a[31]!=b[31]) & (res[31]!=a[31]).
  - Logical and move commands: C and V keep their current register values.
- Latency: flags are visible on status one cycle after the update edge. There is no combinational bypass.
- Direct write: wr_en=1 & ~stall loads wr_data in full. If update and wr_en occur in the same cycle, wr_en wins.
- Counter update (stall=0, flush=0):
  - inc = id_issue_s & ~issue_full.
  - dec = update & (count != 0).
  - inc and dec together: count unchanged.
  - inc only: count+1.
  - dec only: count-1.
- Counter boundaries:
  - Never wraps.
  - issue at full is ignored; the upstream issue logic must stall on issue_full.
  - dec at 0 is ignored, so there is no underflow.
- flush=1: count <- 0, status not updated by EX, wr_en still honoured unless stall=1.
- stall=1 (flush=0): status and count hold.
- flag_hazard = id_needs_flags & (count != 0), purely combinational.
- issue_full = (count == MAX_PENDING).
- Reset mid-operation: count cleared; pending instructions are considered squashed.

Test Plan:
- rst pulse -> status=0000, flag_hazard=0, issue_full=0. Then ADD S, a=0x7FFFFFFF, b=1, res=0x80000000, cout=0 -> next cycle status=N1 Z0 C0 V1 = 4'b1001.
- SUB S (CMP), a=5, b=5, res=0, cout=1 -> status=4'b0110. Then AND S res=0xF0000000 -> status=4'b1010 (C kept at 1, V kept at 0).
- ex_s=0 with ADD producing zero -> status unchanged. Same instruction with stall=1 and ex_s=1 -> status unchanged until stall drops, then updates one cycle later.
- id_issue_s on 3 consecutive cycles (MAX_PENDING=3) -> count 1,2,3, issue_full=1 on the third. A fourth issue is ignored. id_needs_flags=1 gives flag_hazard=1.
- Three EX updates, with issue and update coinciding on one cycle -> count holds on that cycle, then reaches 0 and flag_hazard drops.
- wr_en=1, wr_data=4'b0101 coincident with an ADD S update -> status=4'b0101. flush with count=2 -> count=0, no EX flag update.
